// File: rtl/mio_bus_if.sv
// CPU-side request/response and RAM/IO bus signals for mio_bus_ctrl.
// master: the controller; slave: the CPU/RAM/peripheral environment.
interface mio_bus_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        bus_err;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        io_sel;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ram_rdata, io_rdata, io_ack,
    output cpu_rdata, cpu_ready, bus_err,
    output ram_addr, ram_we, ram_wdata,
    output io_sel, io_we, io_addr, io_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ram_rdata, io_rdata, io_ack,
    input  cpu_rdata, cpu_ready, bus_err,
    input  ram_addr, ram_we, ram_wdata,
    input  io_sel, io_we, io_addr, io_wdata
  );
endinterface

// File: rtl/mio_bus_ctrl.sv
// CPU memory/IO bus controller: RAM at 0x0xxx_xxxx, IO at 0xFxxx_xxxx.
// Define MIO_TIMEOUT_EN to abort IO accesses lacking io_ack.
module mio_bus_ctrl #(
  parameter int unsigned RAM_WAIT   = 1,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input logic       clk,
  input logic       reset,
  mio_bus_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RAM,
    IO,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] wcnt;
  logic       we_q;
  logic       aligned;
  logic       is_ram;
  logic       is_io;
  logic       unused_addr;

`ifdef MIO_TIMEOUT_EN
  logic [7:0] tcnt;
`endif

  assign aligned = bus.cpu_addr[1:0] == 2'b00;
  assign is_ram  = aligned &&
                   bus.cpu_addr[31:28] == 4'h0;
  assign is_io   = aligned &&
                   bus.cpu_addr[31:28] == 4'hF;
  assign unused_addr = ^bus.cpu_addr[27:12];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wcnt          <= '0;
      we_q          <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.io_sel    <= 1'b0;
      bus.io_we     <= 1'b0;
      bus.io_addr   <= '0;
      bus.io_wdata  <= '0;
`ifdef MIO_TIMEOUT_EN
      tcnt          <= '0;
`endif
    end else begin
      bus.cpu_ready <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.ram_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            we_q          <= bus.cpu_we;
            wcnt          <= '0;
            bus.ram_addr  <= bus.cpu_addr[11:2];
            bus.ram_wdata <= bus.cpu_wdata;
            bus.io_addr   <= bus.cpu_addr[7:0];
            bus.io_wdata  <= bus.cpu_wdata;
`ifdef MIO_TIMEOUT_EN
            tcnt          <= '0;
`endif
            unique case (1'b1)
              is_ram: begin
                state      <= RAM;
                bus.ram_we <= bus.cpu_we;
              end
              is_io: begin
                state      <= IO;
                bus.io_sel <= 1'b1;
                bus.io_we  <= bus.cpu_we;
              end
              default: begin
                state         <= DONE;
                bus.cpu_ready <= 1'b1;
                bus.bus_err   <= 1'b1;
                if (!bus.cpu_we)
                  bus.cpu_rdata <= '0;
              end
            endcase
          end
        end
        RAM: begin
          if (wcnt == 3'(RAM_WAIT)) begin
            state         <= DONE;
            bus.cpu_ready <= 1'b1;
            if (!we_q)
              bus.cpu_rdata <= bus.ram_rdata;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        IO: begin
          if (bus.io_ack) begin
            state         <= DONE;
            bus.cpu_ready <= 1'b1;
            bus.io_sel    <= 1'b0;
            bus.io_we     <= 1'b0;
            if (!we_q)
              bus.cpu_rdata <= bus.io_rdata;
          end
`ifdef MIO_TIMEOUT_EN
          else if (tcnt == 8'(IO_TIMEOUT - 1)) begin
            state         <= DONE;
            bus.cpu_ready <= 1'b1;
            bus.bus_err   <= 1'b1;
            bus.io_sel    <= 1'b0;
            bus.io_we     <= 1'b0;
            if (!we_q)
              bus.cpu_rdata <= '0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed testbench for mio_bus_ctrl (RAM_WAIT=1 and RAM_WAIT=3 builds).
module tb_mio_bus_ctrl;

  logic clk;
  logic reset;
  logic use3;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] ram_rd;
  logic [31:0] io_rd;
  logic        io_ack;

  int checks;
  int failures;
  int lat;
  int we_n;
  int sel_n;
  int iowe_n;
  logic err_s;

  mio_bus_if b1();
  mio_bus_if b3();

  mio_bus_ctrl #(.RAM_WAIT(1), .IO_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .bus(b1)
  );

  mio_bus_ctrl #(.RAM_WAIT(3), .IO_TIMEOUT(15)) dut3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  assign b1.cpu_req   = req;
  assign b1.cpu_we    = we;
  assign b1.cpu_addr  = addr;
  assign b1.cpu_wdata = wdata;
  assign b1.ram_rdata = ram_rd;
  assign b1.io_rdata  = io_rd;
  assign b1.io_ack    = io_ack;
  assign b3.cpu_req   = req;
  assign b3.cpu_we    = we;
  assign b3.cpu_addr  = addr;
  assign b3.cpu_wdata = wdata;
  assign b3.ram_rdata = ram_rd;
  assign b3.io_rdata  = io_rd;
  assign b3.io_ack    = io_ack;

  logic        o_ready;
  logic        o_err;
  logic        o_ram_we;
  logic        o_io_sel;
  logic        o_io_we;
  logic [31:0] o_rdata;
  logic [31:0] o_ram_wdata;
  logic [9:0]  o_ram_addr;
  logic [7:0]  o_io_addr;

  always_comb begin
    o_ready     = use3 ? b3.cpu_ready : b1.cpu_ready;
    o_err       = use3 ? b3.bus_err   : b1.bus_err;
    o_ram_we    = use3 ? b3.ram_we    : b1.ram_we;
    o_io_sel    = use3 ? b3.io_sel    : b1.io_sel;
    o_io_we     = use3 ? b3.io_we     : b1.io_we;
    o_rdata     = use3 ? b3.cpu_rdata : b1.cpu_rdata;
    o_ram_wdata = use3 ? b3.ram_wdata : b1.ram_wdata;
    o_ram_addr  = use3 ? b3.ram_addr  : b1.ram_addr;
    o_io_addr   = use3 ? b3.io_addr   : b1.io_addr;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access; ack_at = edge index (after the accept edge)
  // at which io_ack is sampled, 0 for never.
  task automatic run_access(
    input logic [31:0] a,
    input logic        w,
    input logic [31:0] d,
    input int          ack_at,
    input int          max
  );
    int  n;
    bit  done;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    lat    = -1;
    we_n   = 0;
    sel_n  = 0;
    iowe_n = 0;
    err_s  = 1'b0;
    n      = 1;
    done   = 1'b0;
    @(posedge clk);
    while (!done && n <= max) begin
      #1;
      if (o_ram_we) we_n++;
      if (o_io_sel) sel_n++;
      if (o_io_we) iowe_n++;
      if (o_ready) begin
        lat   = n;
        err_s = o_err;
        done  = 1'b1;
      end else begin
        io_ack = (n == ack_at);
        @(posedge clk);
        n++;
      end
    end
    req    = 1'b0;
    io_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (o_ready !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready_err got=%b%b exp=00",
               o_ready, o_err);
    end
    checks++;
    if (o_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_rdata got=%h exp=0", o_rdata);
    end
    checks++;
    if (o_ram_we !== 1'b0 || o_ram_addr !== 10'h0) begin
      failures++;
      $display("FAIL rst_ram got=%b/%h exp=0/0",
               o_ram_we, o_ram_addr);
    end
    checks++;
    if (o_io_sel !== 1'b0 || o_io_we !== 1'b0 ||
        o_io_addr !== 8'h0) begin
      failures++;
      $display("FAIL rst_io got=%b%b/%h exp=00/0",
               o_io_sel, o_io_we, o_io_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ram_read();
    ram_rd = 32'h8D2A_0004;
    run_access(32'h0000_0008, 1'b0, 32'h0, 0, 20);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL ram_rd_lat got=%0d exp=3", lat);
    end
    checks++;
    if (o_rdata !== 32'h8D2A_0004) begin
      failures++;
      $display("FAIL ram_rd_data got=%h exp=8d2a0004",
               o_rdata);
    end
    checks++;
    if (o_ram_addr !== 10'h002) begin
      failures++;
      $display("FAIL ram_rd_addr got=%h exp=002",
               o_ram_addr);
    end
    checks++;
    if (err_s !== 1'b0 || we_n !== 0) begin
      failures++;
      $display("FAIL ram_rd_err got=%b/%0d exp=0/0",
               err_s, we_n);
    end
  endtask

  task automatic test_ram_write();
    ram_rd = 32'hDEAD_BEEF;
    run_access(32'h0000_000C, 1'b1, 32'h0000_4027, 0, 20);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL ram_wr_lat got=%0d exp=3", lat);
    end
    checks++;
    if (we_n !== 1) begin
      failures++;
      $display("FAIL ram_wr_we_cycles got=%0d exp=1", we_n);
    end
    checks++;
    if (o_ram_addr !== 10'h003 ||
        o_ram_wdata !== 32'h0000_4027) begin
      failures++;
      $display("FAIL ram_wr_bus got=%h/%h exp=003/00004027",
               o_ram_addr, o_ram_wdata);
    end
    checks++;
    if (o_rdata !== 32'h8D2A_0004 || err_s !== 1'b0) begin
      failures++;
      $display("FAIL ram_wr_rdata got=%h/%b exp=8d2a0004/0",
               o_rdata, err_s);
    end
  endtask

  task automatic test_io_read();
    io_rd = 32'h0000_00A5;
    run_access(32'hF000_0010, 1'b0, 32'h0, 4, 20);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL io_rd_lat got=%0d exp=5", lat);
    end
    checks++;
    if (sel_n !== 4 || iowe_n !== 0) begin
      failures++;
      $display("FAIL io_rd_sel got=%0d/%0d exp=4/0",
               sel_n, iowe_n);
    end
    checks++;
    if (o_io_addr !== 8'h10) begin
      failures++;
      $display("FAIL io_rd_addr got=%h exp=10", o_io_addr);
    end
    checks++;
    if (o_rdata !== 32'h0000_00A5 || err_s !== 1'b0) begin
      failures++;
      $display("FAIL io_rd_data got=%h/%b exp=000000a5/0",
               o_rdata, err_s);
    end
  endtask

  task automatic test_io_write();
    io_rd = 32'h0000_0077;
    run_access(32'hF000_0024, 1'b1, 32'h1234_5678, 1, 20);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL io_wr_lat got=%0d exp=2", lat);
    end
    checks++;
    if (sel_n !== 1 || iowe_n !== 1) begin
      failures++;
      $display("FAIL io_wr_sel got=%0d/%0d exp=1/1",
               sel_n, iowe_n);
    end
    checks++;
    if (o_io_addr !== 8'h24 ||
        b1.io_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL io_wr_bus got=%h/%h exp=24/12345678",
               o_io_addr, b1.io_wdata);
    end
    checks++;
    if (o_rdata !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL io_wr_rdata got=%h exp=000000a5",
               o_rdata);
    end
  endtask

  task automatic test_errors();
    ram_rd = 32'h1111_2222;
    run_access(32'h0000_0002, 1'b0, 32'h0, 0, 20);
    checks++;
    if (lat !== 1 || err_s !== 1'b1) begin
      failures++;
      $display("FAIL unal_rd got=%0d/%b exp=1/1", lat, err_s);
    end
    checks++;
    if (o_rdata !== 32'h0 || we_n !== 0 || sel_n !== 0) begin
      failures++;
      $display("FAIL unal_rd_side got=%h/%0d/%0d exp=0/0/0",
               o_rdata, we_n, sel_n);
    end
    run_access(32'h0000_0008, 1'b0, 32'h0, 0, 20);
    run_access(32'h8000_0000, 1'b0, 32'h0, 0, 20);
    checks++;
    if (lat !== 1 || err_s !== 1'b1) begin
      failures++;
      $display("FAIL unmap_rd got=%0d/%b exp=1/1", lat, err_s);
    end
    checks++;
    if (o_rdata !== 32'h0 || we_n !== 0 || sel_n !== 0) begin
      failures++;
      $display("FAIL unmap_rd_side got=%h/%0d/%0d exp=0/0/0",
               o_rdata, we_n, sel_n);
    end
    run_access(32'hF000_0006, 1'b1, 32'h5555_AAAA, 1, 20);
    checks++;
    if (lat !== 1 || err_s !== 1'b1 || sel_n !== 0) begin
      failures++;
      $display("FAIL unal_wr got=%0d/%b/%0d exp=1/1/0",
               lat, err_s, sel_n);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] mask;
    mask   = '0;
    ram_rd = 32'h0BAD_F00D;
    req    = 1'b1;
    we     = 1'b0;
    addr   = 32'h0000_0010;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      #1;
      if (o_ready) mask[n] = 1'b1;
      if (n == 8) req = 1'b0;
      @(posedge clk);
    end
    #1;
    checks++;
    if (mask !== 9'h088) begin
      failures++;
      $display("FAIL b2b_ready_mask got=%b exp=010001000",
               mask);
    end
    checks++;
    if (o_rdata !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL b2b_rdata got=%h exp=0badf00d", o_rdata);
    end
  endtask

  task automatic test_timeout();
    io_rd = 32'h0000_0055;
`ifdef MIO_TIMEOUT_EN
    run_access(32'hF000_0000, 1'b0, 32'h0, 0, 40);
    checks++;
    if (lat !== 16 || sel_n !== 15) begin
      failures++;
      $display("FAIL tmo_lat got=%0d/%0d exp=16/15",
               lat, sel_n);
    end
    checks++;
    if (err_s !== 1'b1 || o_rdata !== 32'h0) begin
      failures++;
      $display("FAIL tmo_err got=%b/%h exp=1/0",
               err_s, o_rdata);
    end
`else
    run_access(32'hF000_0000, 1'b0, 32'h0, 0, 100);
    checks++;
    if (lat !== -1) begin
      failures++;
      $display("FAIL no_tmo_ready got=%0d exp=-1", lat);
    end
    checks++;
    if (o_io_sel !== 1'b1 || o_rdata !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL no_tmo_hold got=%b/%h exp=1/0badf00d",
               o_io_sel, o_rdata);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int cnt;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    use3  = 1'b1;
    @(posedge clk);
    #1;
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h0000_0004;
    wdata = 32'h0000_0099;
    @(posedge clk);
    #1;
    checks++;
    if (o_ram_we !== 1'b1) begin
      failures++;
      $display("FAIL mid_we_start got=%b exp=1", o_ram_we);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (o_ram_we !== 1'b0 || o_io_sel !== 1'b0 ||
        o_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_drop got=%b%b%b exp=000",
               o_ram_we, o_io_sel, o_ready);
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cnt   = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (o_ready) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL mid_no_ready got=%0d exp=0", cnt);
    end
    ram_rd = 32'hCAFE_0001;
    run_access(32'h0000_0020, 1'b0, 32'h0, 0, 20);
    checks++;
    if (lat !== 5 || err_s !== 1'b0) begin
      failures++;
      $display("FAIL mid_after_lat got=%0d/%b exp=5/0",
               lat, err_s);
    end
    checks++;
    if (o_rdata !== 32'hCAFE_0001 ||
        o_ram_addr !== 10'h008) begin
      failures++;
      $display("FAIL mid_after_data got=%h/%h exp=cafe0001/008",
               o_rdata, o_ram_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    use3     = 1'b0;
    reset    = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    ram_rd   = '0;
    io_rd    = '0;
    io_ack   = 1'b0;
    test_reset();
    test_ram_read();
    test_ram_write();
    test_io_read();
    test_io_write();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
